// File: rtl/irq_prio_ctrl_if.sv
// Interrupt request / vector handshake bundle between the
// request side (sources, CPU) and the priority controller.
interface irq_prio_ctrl_if #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int VEC_W   = 6
);
    logic                      nmi_req;
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC-1:0]        src_edge;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         cur_level;
    logic                      i_bit;
    logic                      ack;
    logic                      intr_ev;
    logic [VEC_W-1:0]          vt_no;
    logic [PRIO_W-1:0]         int_prio;

    modport master (
        output nmi_req,
        output src_req,
        output src_edge,
        output src_prio,
        output cur_level,
        output i_bit,
        output ack,
        input  intr_ev,
        input  vt_no,
        input  int_prio
    );

    modport slave (
        input  nmi_req,
        input  src_req,
        input  src_edge,
        input  src_prio,
        input  cur_level,
        input  i_bit,
        input  ack,
        output intr_ev,
        output vt_no,
        output int_prio
    );
endinterface

// File: rtl/irq_prio_ctrl.sv
// Registered interrupt priority controller: per-source pending
// latches, priority arbitration, NMI, and a vector/ack handshake.
module irq_prio_ctrl #(
    parameter int NUM_SRC  = 16,
    parameter int PRIO_W   = 3,
    parameter int VEC_W    = 6,
    parameter int VEC_BASE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    irq_prio_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [VEC_W-1:0] NMI_VEC = VEC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] src_set;
    logic [NUM_SRC-1:0] src_clr;
    logic [NUM_SRC-1:0] eligible;
    logic [PRIO_W-1:0]  prio [NUM_SRC];

    logic nmi_q;
    logic nmi_pend;
    logic nmi_pend_nxt;
    logic nmi_set;
    logic nmi_clr;

    logic             sel_nmi;
    logic             sel_nmi_nxt;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] sel_nxt;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [PRIO_W-1:0] win_prio;

    logic              intr_ev_q;
    logic              intr_ev_nxt;
    logic [VEC_W-1:0]  vt_no_q;
    logic [VEC_W-1:0]  vt_no_nxt;
    logic [PRIO_W-1:0] int_prio_q;
    logic [PRIO_W-1:0] int_prio_nxt;

    assign bus.intr_ev  = intr_ev_q;
    assign bus.vt_no    = vt_no_q;
    assign bus.int_prio = int_prio_q;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            prio[i] = bus.src_prio[i*PRIO_W +: PRIO_W];
            eligible[i] = pend[i]
                        & ~bus.i_bit
                        & (prio[i] != '0)
                        & (prio[i] > bus.cur_level);
        end
    end

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!win_valid || prio[i] > win_prio)) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_prio  = prio[i];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        sel_nmi_nxt  = sel_nmi;
        intr_ev_nxt  = intr_ev_q;
        vt_no_nxt    = vt_no_q;
        int_prio_nxt = int_prio_q;
        src_clr      = '0;
        nmi_clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (nmi_pend) begin
                    state_nxt    = ASSERT;
                    sel_nmi_nxt  = 1'b1;
                    intr_ev_nxt  = 1'b1;
                    vt_no_nxt    = NMI_VEC;
                    int_prio_nxt = '1;
                end else if (win_valid) begin
                    state_nxt    = ASSERT;
                    sel_nmi_nxt  = 1'b0;
                    sel_nxt      = win_idx;
                    intr_ev_nxt  = 1'b1;
                    vt_no_nxt    = VEC_W'(VEC_BASE + int'(win_idx));
                    int_prio_nxt = win_prio;
                end
            end
            ASSERT: begin
                if (bus.ack) begin
                    state_nxt    = GAP;
                    intr_ev_nxt  = 1'b0;
                    vt_no_nxt    = '0;
                    int_prio_nxt = '0;
                    if (sel_nmi) begin
                        nmi_clr = 1'b1;
                    end else if (bus.src_edge[sel]) begin
                        src_clr[sel] = 1'b1;
                    end
                end else if (!sel_nmi && nmi_pend) begin
                    sel_nmi_nxt  = 1'b1;
                    vt_no_nxt    = NMI_VEC;
                    int_prio_nxt = '1;
                end else if (!sel_nmi && !eligible[sel]) begin
                    state_nxt    = IDLE;
                    intr_ev_nxt  = 1'b0;
                    vt_no_nxt    = '0;
                    int_prio_nxt = '0;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A fresh edge on the ack cycle survives the clear (set wins).
    always_comb begin
        src_set  = bus.src_req & ~src_q;
        pend_nxt = (bus.src_edge & (src_set | (pend & ~src_clr)))
                 | (~bus.src_edge & bus.src_req);
        nmi_set  = bus.nmi_req & ~nmi_q;
        nmi_pend_nxt = nmi_set | (nmi_pend & ~nmi_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            nmi_q      <= 1'b0;
            pend       <= '0;
            nmi_pend   <= 1'b0;
            state      <= IDLE;
            sel        <= '0;
            sel_nmi    <= 1'b0;
            intr_ev_q  <= 1'b0;
            vt_no_q    <= '0;
            int_prio_q <= '0;
        end else begin
            src_q      <= bus.src_req;
            nmi_q      <= bus.nmi_req;
            pend       <= pend_nxt;
            nmi_pend   <= nmi_pend_nxt;
            state      <= state_nxt;
            sel        <= sel_nxt;
            sel_nmi    <= sel_nmi_nxt;
            intr_ev_q  <= intr_ev_nxt;
            vt_no_q    <= vt_no_nxt;
            int_prio_q <= int_prio_nxt;
        end
    end
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed and randomized bench for irq_prio_ctrl against a
// cycle-level reference model of the pending/present rules.
module tb_irq_prio_ctrl;
    localparam int NS = 16;
    localparam int PW = 3;
    localparam int VW = 6;
    localparam int VB = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irq_prio_ctrl_if #(.NUM_SRC(NS), .PRIO_W(PW), .VEC_W(VW)) bus ();

    irq_prio_ctrl #(
        .NUM_SRC(NS), .PRIO_W(PW), .VEC_W(VW), .VEC_BASE(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit m_pend [NS];
    bit m_last [NS];
    bit m_nmi_pend;
    bit m_nmi_last;
    bit m_busy;
    bit m_gap;
    bit m_on_nmi;
    int m_sel;
    int exp_ev;
    int exp_vt;
    int exp_prio;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, act, exp, $time);
        end
    endtask

    function automatic int p(input int i);
        return int'(bus.src_prio[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0;
            m_last[i] = 0;
        end
        m_nmi_pend = 0;
        m_nmi_last = 0;
        m_busy = 0;
        m_gap = 0;
        m_on_nmi = 0;
        m_sel = 0;
        exp_ev = 0;
        exp_vt = 0;
        exp_prio = 0;
    endtask

    task automatic show(input bit nmi, input int idx);
        m_busy = 1;
        m_on_nmi = nmi;
        m_sel = idx;
        exp_ev = 1;
        exp_vt = nmi ? 1 : (VB + idx) % (1 << VW);
        exp_prio = nmi ? (1 << PW) - 1 : p(idx);
    endtask

    task automatic drop_out();
        exp_ev = 0;
        exp_vt = 0;
        exp_prio = 0;
    endtask

    task automatic model_step();
        bit elig [NS];
        int win;
        int best;
        int clr;
        bit clr_nmi;
        bit nr;
        clr = -1;
        clr_nmi = 0;
        win = -1;
        best = 0;
        for (int i = 0; i < NS; i++) begin
            elig[i] = m_pend[i] && !bus.i_bit && p(i) > int'(bus.cur_level);
            if (elig[i] && p(i) > best) begin
                best = p(i);
                win = i;
            end
        end
        if (m_gap) begin
            m_gap = 0;
        end else if (!m_busy) begin
            if (m_nmi_pend) show(1, 0);
            else if (win >= 0) show(0, win);
        end else if (bus.ack) begin
            if (m_on_nmi) clr_nmi = 1;
            else if (bus.src_edge[m_sel]) clr = m_sel;
            m_busy = 0;
            m_gap = 1;
            drop_out();
        end else if (!m_on_nmi && m_nmi_pend) begin
            show(1, 0);
        end else if (!m_on_nmi && !elig[m_sel]) begin
            m_busy = 0;
            drop_out();
        end
        for (int i = 0; i < NS; i++) begin
            if (!bus.src_edge[i]) m_pend[i] = bus.src_req[i];
            else if (bus.src_req[i] && !m_last[i]) m_pend[i] = 1;
            else if (i == clr) m_pend[i] = 0;
            m_last[i] = bus.src_req[i];
        end
        nr = bus.nmi_req;
        if (nr && !m_nmi_last) m_nmi_pend = 1;
        else if (clr_nmi) m_nmi_pend = 0;
        m_nmi_last = nr;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("intr_ev", bus.intr_ev, exp_ev);
        chk("vt_no", bus.vt_no, exp_vt);
        chk("int_prio", bus.int_prio, exp_prio);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_src(input int i, input bit edg, input int pr);
        bus.src_edge[i] = edg;
        bus.src_prio[i*PW +: PW] = PW'(pr);
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        bus.src_req = bus.src_req | m;
        cycle();
        bus.src_req = bus.src_req & ~m;
    endtask

    task automatic ack_wait();
        bus.ack = 1'b1;
        cycle();
        bus.ack = 1'b0;
        cycles(2);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ev", bus.intr_ev, 0);
        chk("rst_vt", bus.vt_no, 0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.nmi_req = 1'b0;
        bus.src_req = '0;
        bus.src_edge = '0;
        bus.src_prio = '0;
        bus.cur_level = '0;
        bus.i_bit = 1'b0;
        bus.ack = 1'b0;
        model_reset();
        #12;
        chk("reset_ev", bus.intr_ev, 0);
        chk("reset_vt", bus.vt_no, 0);
        chk("reset_prio", bus.int_prio, 0);
        @(negedge clk) rst_n = 1'b1;

        set_src(5, 1, 4);
        pulse(16'h0020);
        chk("lat_k", bus.intr_ev, 0);
        cycle();
        chk("lat_vt", bus.vt_no, 7);
        chk("lat_prio", bus.int_prio, 4);
        bus.ack = 1'b1;
        cycle();
        bus.ack = 1'b0;
        chk("ack_ev", bus.intr_ev, 0);
        chk("pend5", dut.pend[5], 0);
        cycles(2);
        set_src(5, 0, 0);

        set_src(3, 1, 6);
        set_src(9, 1, 6);
        set_src(12, 1, 7);
        pulse(16'h1208);
        cycle();
        chk("top_vt", bus.vt_no, 14);
        ack_wait();
        chk("tie_vt", bus.vt_no, 5);
        ack_wait();
        chk("next_vt", bus.vt_no, 11);
        ack_wait();
        set_src(3, 0, 0);
        set_src(9, 0, 0);
        set_src(12, 0, 0);

        set_src(0, 1, 2);
        pulse(16'h0001);
        cycle();
        chk("src0_vt", bus.vt_no, 2);
        bus.nmi_req = 1'b1;
        cycles(2);
        bus.nmi_req = 1'b0;
        chk("nmi_vt", bus.vt_no, 1);
        chk("nmi_prio", bus.int_prio, 7);
        chk("nmi_ev", bus.intr_ev, 1);
        ack_wait();
        chk("src0_again", bus.vt_no, 2);
        ack_wait();
        set_src(0, 0, 0);

        set_src(4, 1, 5);
        pulse(16'h0010);
        cycle();
        chk("src4_vt", bus.vt_no, 6);
        bus.src_req[4] = 1'b1;
        bus.ack = 1'b1;
        cycle();
        bus.ack = 1'b0;
        bus.src_req[4] = 1'b0;
        chk("set_wins", dut.pend[4], 1);
        cycles(2);
        chk("src4_again", bus.vt_no, 6);
        ack_wait();
        set_src(4, 0, 0);

        set_src(2, 0, 3);
        bus.cur_level = 3'd3;
        bus.src_req[2] = 1'b1;
        cycles(3);
        chk("masked_ev", bus.intr_ev, 0);
        bus.cur_level = 3'd2;
        cycle();
        chk("lvl_vt", bus.vt_no, 4);
        bus.i_bit = 1'b1;
        cycle();
        chk("withdraw", bus.intr_ev, 0);
        bus.i_bit = 1'b0;
        bus.src_req[2] = 1'b0;
        bus.cur_level = 3'd0;
        cycles(4);
        set_src(2, 0, 0);

        set_src(1, 0, 1);
        bus.src_req[1] = 1'b1;
        cycles(2);
        chk("src1_vt", bus.vt_no, 3);
        mid_reset();
        cycle();
        chk("post_rst1", bus.intr_ev, 0);
        cycle();
        chk("post_rst2", bus.vt_no, 3);
        bus.src_req[1] = 1'b0;
        cycles(3);

        for (int i = 0; i < NS; i++) set_src(i, $urandom_range(0, 1), $urandom_range(0, 7));
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0)
                bus.src_req = bus.src_req ^ NS'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 99) == 0) bus.src_edge = NS'($urandom);
            if ($urandom_range(0, 149) == 0)
                for (int i = 0; i < NS; i++) set_src(i, bus.src_edge[i], $urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) bus.cur_level = PW'($urandom);
            if ($urandom_range(0, 39) == 0) bus.i_bit = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) bus.nmi_req = ~bus.nmi_req;
            bus.ack = ($urandom_range(0, 2) == 0);
            cycle();
            if ($urandom_range(0, 499) == 0) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
